// File: rtl/cache_responder_if.sv
// Cache request/valid handshake bundle between a master-side initiator and
// the cache_responder slave. addr/d are tri-state and stay as plain ports.
interface cache_responder_if;
    logic [1:0] operation;
    logic       request;
    logic       valid;
    logic       evict;

    modport master (
        output operation,
        output request,
        input  valid,
        input  evict
    );

    modport slave (
        input  operation,
        input  request,
        output valid,
        output evict
    );
endinterface

// File: rtl/cache_responder.sv
// Direct-mapped, write-back, write-allocate cache responder with one data word
// per line. Serves READ/WRITE/INVALIDATE over a 4-phase request/valid handshake
// and uses a single-outstanding backing-memory port for fills and write-backs.
// Optional feature macro: CACHE_STATS_EN enables saturating hit/miss counters;
// when undefined the counter outputs are tied to zero.
module cache_responder #(
    parameter int unsigned DATAWIDTH    = 8,
    parameter int unsigned ADDRESSWIDTH = 32,
    parameter int unsigned SETS         = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    cache_responder_if.slave        bus,
    inout  wire [ADDRESSWIDTH-1:0]  addr,
    inout  wire [DATAWIDTH-1:0]     d,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDRESSWIDTH-1:0] mem_addr,
    output logic [DATAWIDTH-1:0]    mem_wdata,
    input  logic [DATAWIDTH-1:0]    mem_rdata,
    input  logic                    mem_ack,
    output logic [15:0]             hit_count,
    output logic [15:0]             miss_count
);
    localparam int unsigned IDX  = $clog2(SETS);
    localparam int unsigned TAGW = ADDRESSWIDTH - IDX;

    localparam logic [1:0] OpNop   = 2'd0;
    localparam logic [1:0] OpRead  = 2'd1;
    localparam logic [1:0] OpWrite = 2'd2;
    localparam logic [1:0] OpInv   = 2'd3;

    typedef enum logic [2:0] {StIdle, StLookup, StWb, StFill, StResp} state_e;

    state_e                  r_state;
    state_e                  w_next_state;

    // Captured request
    logic [1:0]              r_op;
    logic [ADDRESSWIDTH-1:0] r_addr;
    logic [DATAWIDTH-1:0]    r_wdata;
    logic [DATAWIDTH-1:0]    r_rdata;
    logic                    r_evict;
    logic                    r_valid;

    // Backing-memory request registers
    logic                    r_mem_req;
    logic                    r_mem_we;
    logic [ADDRESSWIDTH-1:0] r_mem_addr;
    logic [DATAWIDTH-1:0]    r_mem_wdata;

    // Line state
    logic [SETS-1:0]         r_line_valid;
    logic [SETS-1:0]         r_line_dirty;
    logic [TAGW-1:0]         r_tag  [SETS];
    logic [DATAWIDTH-1:0]    r_data [SETS];

    logic [IDX-1:0]          w_idx;
    logic [TAGW-1:0]         w_tag;
    logic                    w_hit;
    logic                    w_victim_dirty;
    logic                    w_ack;
    logic                    w_d_oe;

    assign w_idx          = r_addr[IDX-1:0];
    assign w_tag          = r_addr[ADDRESSWIDTH-1:IDX];
    assign w_hit          = r_line_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_victim_dirty = r_line_valid[w_idx] && r_line_dirty[w_idx];
    // An ack only counts while a backing access is actually outstanding.
    assign w_ack          = r_mem_req && mem_ack;

    assign bus.valid = r_valid;
    assign bus.evict = r_valid && r_evict;
    assign w_d_oe    = r_valid && (r_op == OpRead);
    assign d         = w_d_oe ? r_rdata : {DATAWIDTH{1'bz}};
    // The address bus is owned by the master; this block only samples it.
    assign addr      = {ADDRESSWIDTH{1'bz}};

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            StIdle: begin
                if (bus.request) begin
                    w_next_state = StLookup;
                end
            end
            StLookup: begin
                if (r_op == OpNop) begin
                    w_next_state = StResp;
                end else if (w_hit) begin
                    w_next_state = (r_op == OpInv && r_line_dirty[w_idx]) ? StWb : StResp;
                end else if (r_op == OpInv) begin
                    w_next_state = StResp;
                end else begin
                    w_next_state = w_victim_dirty ? StWb : StFill;
                end
            end
            StWb: begin
                if (w_ack) begin
                    w_next_state = (r_op == OpInv) ? StResp : StFill;
                end
            end
            StFill: begin
                if (w_ack) begin
                    w_next_state = StResp;
                end
            end
            StResp: begin
                if (!bus.request) begin
                    w_next_state = StIdle;
                end
            end
            default: w_next_state = StIdle;
        endcase
    end

    // Request capture, response, memory request and line valid/dirty updates
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op         <= OpNop;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_evict      <= 1'b0;
            r_valid      <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_line_valid <= '0;
            r_line_dirty <= '0;
        end else begin
            // valid is held one edge behind RESP and drops with the request
            r_valid <= (r_state == StResp) && bus.request;
            unique case (r_state)
                StIdle: begin
                    if (bus.request) begin
                        r_op    <= bus.operation;
                        r_addr  <= addr;
                        r_wdata <= d;
                        r_evict <= 1'b0;
                    end
                end
                StLookup: begin
                    if (w_next_state == StWb) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= {r_tag[w_idx], w_idx};
                        r_mem_wdata <= r_data[w_idx];
                        r_evict     <= 1'b1;
                    end else if (w_next_state == StFill) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_addr;
                    end
                    if (w_hit && r_op == OpRead) begin
                        r_rdata <= r_data[w_idx];
                    end
                    if (w_hit && r_op == OpWrite) begin
                        r_line_dirty[w_idx] <= 1'b1;
                    end
                    if (w_hit && r_op == OpInv && !r_line_dirty[w_idx]) begin
                        r_line_valid[w_idx] <= 1'b0;
                    end
                end
                StWb: begin
                    if (w_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (r_op == OpInv) begin
                            r_line_valid[w_idx] <= 1'b0;
                            r_line_dirty[w_idx] <= 1'b0;
                        end
                    end
                end
                StFill: begin
                    // After a write-back, req is low for one cycle before the fill.
                    if (!r_mem_req) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_addr;
                    end else if (mem_ack) begin
                        r_mem_req           <= 1'b0;
                        r_line_valid[w_idx] <= 1'b1;
                        r_line_dirty[w_idx] <= (r_op == OpWrite);
                        if (r_op == OpRead) begin
                            r_rdata <= mem_rdata;
                        end
                    end
                end
                StResp: begin
                    if (!bus.request) begin
                        r_evict <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag/data storage; contents are qualified by r_line_valid so no reset is needed
    always_ff @(posedge clock) begin
        if (r_state == StLookup && w_hit && r_op == OpWrite) begin
            r_data[w_idx] <= r_wdata;
        end
        if (r_state == StFill && w_ack) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= (r_op == OpWrite) ? r_wdata : mem_rdata;
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    // Saturating hit/miss counters for READ/WRITE lookups
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_state == StLookup && (r_op == OpRead || r_op == OpWrite)) begin
            if (w_hit) begin
                if (r_hit_count != 16'hFFFF) begin
                    r_hit_count <= r_hit_count + 16'd1;
                end
            end else if (r_miss_count != 16'hFFFF) begin
                r_miss_count <= r_miss_count + 16'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    assign hit_count  = 16'd0;
    assign miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_cache_responder.sv
// Self-checking bench for cache_responder: directed scenarios followed by
// random traffic, checked against a flat-memory reference plus a per-set
// valid/dirty/tag model.
module tb_cache_responder;
    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 32;
    localparam int unsigned SETS = 16;

    localparam logic [1:0] OpNop   = 2'd0;
    localparam logic [1:0] OpRead  = 2'd1;
    localparam logic [1:0] OpWrite = 2'd2;
    localparam logic [1:0] OpInv   = 2'd3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    wire  [AW-1:0] addr;
    wire  [DW-1:0] d;
    logic [AW-1:0] m_addr;
    logic          m_addr_oe;
    logic [DW-1:0] m_d;
    logic          m_d_oe;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic [15:0]   hit_count;
    logic [15:0]   miss_count;

    cache_responder_if bus_if ();

    assign addr = m_addr_oe ? m_addr : {AW{1'bz}};
    assign d    = m_d_oe ? m_d : {DW{1'bz}};

    cache_responder #(
        .DATAWIDTH    (DW),
        .ADDRESSWIDTH (AW),
        .SETS         (SETS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus_if),
        .addr       (addr),
        .d          (d),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Backing memory (environment) and architectural flat memory (reference)
    logic [DW-1:0] bmem [logic [AW-1:0]];
    logic [DW-1:0] arch [logic [AW-1:0]];

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
    endfunction

    function automatic logic [DW-1:0] bmem_rd(input logic [AW-1:0] a);
        return bmem.exists(a) ? bmem[a] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] arch_rd(input logic [AW-1:0] a);
        return arch.exists(a) ? arch[a] : init_val(a);
    endfunction

    // Observed backing transactions
    logic [AW+DW-1:0] wb_q [$];
    logic [AW-1:0]    fill_q [$];
    logic             mem_hold  = 1'b0;
    int               fixed_dly = -1;
    int               late_req  = 0;
    int               late_done = 0;

    // Backing-memory responder: random 0..3 cycle latency, one-cycle ack pulse
    initial begin
        int wait_cnt;
        wait_cnt  = -1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clock);
            #1;
            mem_ack = 1'b0;
            if (late_done != late_req) begin
                late_done = late_req;
                mem_ack   = 1'b1;
                mem_rdata = 8'hEE;
            end else if (reset || !mem_req || mem_hold) begin
                wait_cnt = -1;
            end else begin
                if (wait_cnt < 0) begin
                    wait_cnt = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
                end
                if (wait_cnt == 0) begin
                    mem_ack  = 1'b1;
                    wait_cnt = -1;
                    if (mem_we) begin
                        bmem[mem_addr] = mem_wdata;
                        wb_q.push_back({mem_addr, mem_wdata});
                    end else begin
                        mem_rdata = bmem_rd(mem_addr);
                        fill_q.push_back(mem_addr);
                    end
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Reference cache bookkeeping: which address each set holds and whether dirty
    logic          mv [SETS];
    logic          md [SETS];
    logic [27:0]   mt [SETS];
    int unsigned   exp_hits;
    int unsigned   exp_miss;

    task automatic model_reset();
        for (int i = 0; i < SETS; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
            mt[i] = '0;
        end
        exp_hits = 0;
        exp_miss = 0;
        // Dirty data held in the cache is lost; memory is what remains.
        arch.delete();
        foreach (bmem[k]) arch[k] = bmem[k];
    endtask

    // One full 4-phase transaction with prediction and checking.
    // lat counts clock edges from request to the edge that raises valid.
    task automatic run_op(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input int hold, output logic [DW-1:0] rd, output int lat);
        logic [3:0]    idx;
        logic [27:0]   tg;
        logic          hit;
        logic          wb;
        logic          fill;
        logic [AW-1:0] va;
        logic [DW-1:0] vdat;
        logic [DW-1:0] exp_rd;
        logic          ev;
        logic          ok;
        int            n;
        idx  = a[3:0];
        tg   = a[31:4];
        hit  = mv[idx] && (mt[idx] == tg);
        va   = {mt[idx], idx};
        wb   = 1'b0;
        fill = 1'b0;
        if (op == OpRead || op == OpWrite) begin
            if (hit) begin
                exp_hits++;
            end else begin
                exp_miss++;
                fill = 1'b1;
                wb   = mv[idx] && md[idx];
            end
        end else if (op == OpInv) begin
            wb = hit && md[idx];
        end
        vdat = arch_rd(va);
        if (op == OpWrite) arch[a] = wd;
        exp_rd = arch_rd(a);
        if (fill) begin
            mv[idx] = 1'b1;
            mt[idx] = tg;
            md[idx] = 1'b0;
        end
        if (op == OpWrite) md[idx] = 1'b1;
        if (op == OpInv && hit) begin
            mv[idx] = 1'b0;
            md[idx] = 1'b0;
        end

        wb_q.delete();
        fill_q.delete();
        @(negedge clock);
        bus_if.operation = op;
        bus_if.request   = 1'b1;
        m_addr           = a;
        m_d              = wd;
        m_d_oe           = (op != OpRead);
        lat = 0;
        while (!bus_if.valid && lat < 60) begin
            @(negedge clock);
            lat++;
        end
        check_eq("valid_seen", bus_if.valid, 1'b1);
        rd = d;
        ev = bus_if.evict;
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            if (!bus_if.valid) ok = 1'b0;
        end
        if (hold > 0) check_eq("hold_valid", ok, 1'b1);
        bus_if.request = 1'b0;
        m_d_oe         = 1'b0;
        n = 0;
        while (bus_if.valid && n < 10) begin
            @(negedge clock);
            n++;
        end
        check_eq("valid_drop", n, 1);
        if (op == OpRead) check_eq("rdata", rd, exp_rd);
        check_eq("evict", ev, wb);
        check_eq("wb_count", wb_q.size(), wb);
        check_eq("fill_count", fill_q.size(), fill);
        if (wb && wb_q.size() > 0) check_eq("wb_addr_data", wb_q[0], {va, vdat});
        if (fill && fill_q.size() > 0) check_eq("fill_addr", fill_q[0], a);
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rd;
        int            lat;
        logic [AW-1:0] ra;
        logic [27:0]   tags [4];
        tags[0] = 28'h0;
        tags[1] = 28'h1;
        tags[2] = 28'h2;
        tags[3] = 28'hFFFFFFF;

        bus_if.operation = OpNop;
        bus_if.request   = 1'b0;
        m_addr           = '0;
        m_addr_oe        = 1'b1;
        m_d              = '0;
        m_d_oe           = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        check_eq("rst_valid", bus_if.valid, 1'b0);
        check_eq("rst_evict", bus_if.evict, 1'b0);
        check_eq("rst_mem_req", mem_req, 1'b0);
        check_eq("rst_mem_we", mem_we, 1'b0);
        check_eq("rst_mem_addr", mem_addr, '0);
        check_eq("rst_mem_wdata", mem_wdata, '0);
        check_eq("rst_hit_count", hit_count, '0);
        check_eq("rst_miss_count", miss_count, '0);

        // Cold read with fixed memory latency, then a hit
        bmem[32'h13] = 8'hA5;
        arch[32'h13] = 8'hA5;
        fixed_dly = 3;
        run_op(OpRead, 32'h13, 8'h00, 0, rd, lat);
        check_eq("cold_rdata", rd, 8'hA5);
        check_eq("cold_latency", lat, 7);
        fixed_dly = -1;
        run_op(OpRead, 32'h13, 8'h00, 0, rd, lat);
        check_eq("hit_latency", lat, 3);

        // Dirty victim write-back on a conflicting read
        run_op(OpWrite, 32'h13, 8'h5C, 0, rd, lat);
        run_op(OpRead, 32'h23, 8'h00, 0, rd, lat);

        // Invalidate a dirty line, then it must miss
        run_op(OpWrite, 32'h23, 8'h77, 0, rd, lat);
        run_op(OpInv, 32'h23, 8'h00, 0, rd, lat);
        run_op(OpRead, 32'h23, 8'h00, 0, rd, lat);
        check_eq("inv_reread", rd, 8'h77);

        // Reset asserted while a fill is outstanding
        mem_hold = 1'b1;
        @(negedge clock);
        bus_if.operation = OpRead;
        m_addr           = 32'h45;
        bus_if.request   = 1'b1;
        lat = 0;
        while (!mem_req && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check_eq("rst_fill_req", mem_req, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("async_rst_mem_req", mem_req, 1'b0);
        check_eq("async_rst_valid", bus_if.valid, 1'b0);
        check_eq("async_rst_mem_addr", mem_addr, '0);
        bus_if.request = 1'b0;
        @(negedge clock);
        reset    = 1'b0;
        mem_hold = 1'b0;
        late_req++;
        repeat (3) @(negedge clock);
        check_eq("late_ack_mem_req", mem_req, 1'b0);
        check_eq("late_ack_valid", bus_if.valid, 1'b0);
        model_reset();

        // Statistics: 2 misses then 3 hits; the last one holds request
        run_op(OpRead, 32'h45, 8'h00, 0, rd, lat);
        run_op(OpRead, 32'h46, 8'h00, 0, rd, lat);
        run_op(OpRead, 32'h45, 8'h00, 0, rd, lat);
        run_op(OpWrite, 32'h46, 8'hC3, 0, rd, lat);
        run_op(OpRead, 32'h46, 8'h00, 5, rd, lat);
        check_eq("hold_rdata", rd, 8'hC3);
        repeat (4) @(negedge clock);
        check_eq("no_second_txn_valid", bus_if.valid, 1'b0);
        check_eq("no_second_txn_mem", wb_q.size() + fill_q.size(), 0);
`ifdef CACHE_STATS_EN
        check_eq("dir_hit_count", hit_count, 16'd3);
        check_eq("dir_miss_count", miss_count, 16'd2);
`else
        check_eq("dir_hit_count", hit_count, 16'd0);
        check_eq("dir_miss_count", miss_count, 16'd0);
`endif

        // Random traffic over a small address pool, including all-ones tags
        for (int t = 0; t < 300; t++) begin
            ra = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, SETS - 1))};
            run_op(2'($urandom_range(0, 3)), ra, 8'($urandom), int'($urandom_range(0, 1)), rd, lat);
        end
        run_op(OpRead, 32'hFFFF_FFFF, 8'h00, 0, rd, lat);

`ifdef CACHE_STATS_EN
        check_eq("final_hit_count", hit_count, 16'(exp_hits));
        check_eq("final_miss_count", miss_count, 16'(exp_miss));
`else
        check_eq("final_hit_count", hit_count, 16'd0);
        check_eq("final_miss_count", miss_count, 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
